// File: rtl/parity_frame_checker_if.sv
// Bit-level input and word-level result bundle for parity_frame_checker.
// err_cnt is present only when PFC_ERR_CNT_EN is defined.
interface parity_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              din;
  logic              din_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              parity_err;
  logic              busy;
`ifdef PFC_ERR_CNT_EN
  logic [7:0]        err_cnt;

  modport master (
    output start, din, din_valid,
    input  data_out, out_valid, parity_err, busy, err_cnt
  );
  modport slave (
    input  start, din, din_valid,
    output data_out, out_valid, parity_err, busy, err_cnt
  );
`else
  modport master (
    output start, din, din_valid,
    input  data_out, out_valid, parity_err, busy
  );
  modport slave (
    input  start, din, din_valid,
    output data_out, out_valid, parity_err, busy
  );
`endif
endinterface

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_W data bits LSB-first plus one parity bit, reported as a word.
// Optional saturating parity-error counter enabled by PFC_ERR_CNT_EN.
module parity_frame_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  parity_frame_checker_if.slave pfc
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic [CW-1:0]     r_cnt;
  logic              r_acc;
  logic              r_valid;
  logic              r_perr;
  logic              r_busy;
`ifdef PFC_ERR_CNT_EN
  logic [7:0]        r_err_cnt;
`endif

  logic [DATA_W-1:0] w_shift_next;
  logic              w_perr;

  // New bit enters at the MSB so the first-received bit ends up at bit 0.
  always_comb begin
    w_shift_next             = r_shift >> 1;
    w_shift_next[DATA_W-1]   = pfc.din;
  end

  assign w_perr = (r_acc ^ pfc.din) != ODD_PARITY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_acc     <= 1'b0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef PFC_ERR_CNT_EN
      r_err_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pfc.start) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_DATA: begin
          if (pfc.din_valid) begin
            r_shift <= w_shift_next;
            r_acc   <= r_acc ^ pfc.din;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CW'(DATA_W - 1)) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          // Result registered on the parity edge so out_valid coincides with DONE.
          if (pfc.din_valid) begin
            r_data  <= r_shift;
            r_perr  <= w_perr;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef PFC_ERR_CNT_EN
          if (r_perr && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pfc.data_out   = r_data;
  assign pfc.out_valid  = r_valid;
  assign pfc.parity_err = r_perr;
  assign pfc.busy       = r_busy;
`ifdef PFC_ERR_CNT_EN
  assign pfc.err_cnt    = r_err_cnt;
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: even- and odd-parity instances share one stimulus stream,
// a queue-based frame model is compared every cycle, plus literal per-frame expectations.
module tb_parity_frame_checker;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic din   = 1'b0;
  logic din_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_W(8)) if_e ();
  parity_frame_checker_if #(.DATA_W(8)) if_o ();

  assign if_e.start     = start;
  assign if_e.din       = din;
  assign if_e.din_valid = din_valid;
  assign if_o.start     = start;
  assign if_o.din       = din;
  assign if_o.din_valid = din_valid;

  parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_even (
    .clk   (clk),
    .rst_n (rst_n),
    .pfc   (if_e.slave)
  );

  parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .pfc   (if_o.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: collect sampled bits, evaluate the word once DATA_W+1 bits are in.
  logic       m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_perr_e = 1'b0, m_perr_o = 1'b0;
  int         m_cnt_e = 0, m_cnt_o = 0;
  logic       m_bits[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_data = '0;
      m_perr_e = 1'b0; m_perr_o = 1'b0; m_cnt_e = 0; m_cnt_o = 0;
      m_bits.delete();
    end else if (m_done) begin
      m_done  = 1'b0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      if (m_perr_e && m_cnt_e < 255) m_cnt_e++;
      if (m_perr_o && m_cnt_o < 255) m_cnt_o++;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_bits.delete();
      end
    end else if (din_valid) begin
      m_bits.push_back(din);
      if (m_bits.size() == 9) begin
        int ones;
        m_data = '0;
        for (int unsigned i = 0; i < 8; i++) m_data[i] = m_bits[i];
        ones     = $countones(m_data) + int'(m_bits[8]);
        m_perr_e = (ones % 2) != 0;
        m_perr_o = (ones % 2) != 1;
        m_valid  = 1'b1;
        m_done   = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("valid_e", 32'(if_e.out_valid), 32'(m_valid));
      chk("valid_o", 32'(if_o.out_valid), 32'(m_valid));
      chk("busy_e",  32'(if_e.busy),      32'(m_busy));
      chk("busy_o",  32'(if_o.busy),      32'(m_busy));
      chk("data_e",  32'(if_e.data_out),  32'(m_data));
      chk("data_o",  32'(if_o.data_out),  32'(m_data));
      chk("perr_e",  32'(if_e.parity_err), 32'(m_perr_e));
      chk("perr_o",  32'(if_o.parity_err), 32'(m_perr_o));
`ifdef PFC_ERR_CNT_EN
      chk("cnt_e",   32'(if_e.err_cnt),   32'(m_cnt_e));
      chk("cnt_o",   32'(if_o.err_cnt),   32'(m_cnt_o));
`endif
    end
  end

  // gap: insert an idle (din_valid=0) cycle before every bit; mid_start: pulse start during bit 4.
  task automatic send_frame(input string nm, input logic [7:0] w, input logic p,
                            input bit gap, input bit mid_start,
                            input logic e_err, input logic o_err);
    @(negedge clk);
    start = 1'b1; din_valid = 1'b1; din = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        @(negedge clk);
        start = 1'b0; din_valid = 1'b0; din = ~w[i];
      end
      @(negedge clk);
      start = mid_start && (i == 4); din_valid = 1'b1; din = w[i];
    end
    @(negedge clk);
    start = mid_start; din_valid = 1'b1; din = p;
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 32'(if_e.out_valid),  32'd1);
    chk({nm, "_data"},  32'(if_e.data_out),   32'(w));
    chk({nm, "_perr_e"}, 32'(if_e.parity_err), 32'(e_err));
    chk({nm, "_perr_o"}, 32'(if_o.parity_err), 32'(o_err));
    @(negedge clk);
    start = 1'b0; din_valid = 1'b0; din = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_valid_drop"}, 32'(if_e.out_valid), 32'd0);
    chk({nm, "_idle"},       32'(if_e.busy),      32'd0);
    chk({nm, "_data_held"},  32'(if_e.data_out),  32'(w));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_data",  32'(if_e.data_out),   32'd0);
    chk("rst_valid", 32'(if_e.out_valid),  32'd0);
    chk("rst_perr",  32'(if_e.parity_err), 32'd0);
    chk("rst_busy",  32'(if_e.busy),       32'd0);
`ifdef PFC_ERR_CNT_EN
    chk("rst_cnt",   32'(if_e.err_cnt),    32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("init_data",  32'(if_e.data_out),  32'd0);
    chk("init_valid", 32'(if_e.out_valid), 32'd0);
    chk("init_busy",  32'(if_o.busy),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send_frame("t1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("t2", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("t3", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Partial frame of 0x81 (bits 1,0,0) abandoned by reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; din_valid = 1'b1; din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    din = 1'b0;
    do_reset();
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_no_valid", 32'(if_e.out_valid), 32'd0);
    send_frame("t4", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send_frame("t5a", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("t5b", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    do_reset();
    send_frame("t6a", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("t6b", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("t6c", 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame("t6d", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef PFC_ERR_CNT_EN
    chk("t6_err_cnt_e", 32'(if_e.err_cnt), 32'd3);
    chk("t6_err_cnt_o", 32'(if_o.err_cnt), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
